prod_accumulator: RTL and testbench

Downstream consumer of the 4-bit shift/add multiplier's registered 8-bit product. Sums a fixed number of consecutive products (a dot-product / MAC tail) into a wider accumulator and presents each finished sum on a valid/ready output port. One product is accepted per cycle while accumulating. Overflow is flagged, and the sum either wraps or saturates depending on build configuration.

---
 rtl/prod_accumulator_if.sv | 24 ++
 rtl/prod_accumulator.sv | 105 ++++++++++
 tb/tb_prod_accumulator.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/prod_accumulator_if.sv
// rtl/prod_accumulator_if.sv - product input / result output handshake bundle for prod_accumulator
interface prod_accumulator_if #(
    parameter int PROD_W = 8,
    parameter int ACC_W  = 12
) ();
    logic              clear;
    logic              in_valid;
    logic [PROD_W-1:0] in_product;
    logic              in_ready;
    logic              out_valid;
    logic [ACC_W-1:0]  out_sum;
    logic              out_ovf;
    logic              out_ready;

    modport master (
        output clear, in_valid, in_product, out_ready,
        input  in_ready, out_valid, out_sum, out_ovf
    );

    modport slave (
        input  clear, in_valid, in_product, out_ready,
        output in_ready, out_valid, out_sum, out_ovf
    );
endinterface

// File: rtl/prod_accumulator.sv
// rtl/prod_accumulator.sv - sums COUNT products per result; ACC_SAT_EN selects saturate instead of wrap
module prod_accumulator #(
    parameter int PROD_W = 8,
    parameter int ACC_W  = 12,
    parameter int COUNT  = 4
) (
    input  logic clk,
    input  logic rst,
    prod_accumulator_if.slave bus
);
    typedef enum logic {S_ACCUM, S_DONE} state_t;

    localparam logic [7:0] LAST_IDX = 8'(COUNT - 1);

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [7:0]         cnt_q, cnt_d;
    logic               ovf_q, ovf_d;
    logic [ACC_W-1:0]   out_sum_q, out_sum_d;
    logic               out_ovf_q, out_ovf_d;

    logic               in_ready;
    logic               accept;
    logic [ACC_W:0]     sum_wide;
    logic               carry;
    logic [ACC_W-1:0]   sum_kept;

    // Handshake outputs depend only on registered state and clear.
    assign in_ready      = (state_q == S_ACCUM) && !bus.clear;
    assign bus.in_ready  = in_ready;
    assign bus.out_valid = (state_q == S_DONE) && !bus.clear;
    assign bus.out_sum   = out_sum_q;
    assign bus.out_ovf   = out_ovf_q;

    assign accept   = bus.in_valid && in_ready;
    assign sum_wide = {1'b0, acc_q} + {{(ACC_W + 1 - PROD_W){1'b0}}, bus.in_product};
    assign carry    = sum_wide[ACC_W];

`ifdef ACC_SAT_EN
    // A saturated acc stays all-ones: any further add carries again.
    assign sum_kept = carry ? {ACC_W{1'b1}} : sum_wide[ACC_W-1:0];
`else
    assign sum_kept = sum_wide[ACC_W-1:0];
`endif

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        ovf_d     = ovf_q;
        out_sum_d = out_sum_q;
        out_ovf_d = out_ovf_q;

        if (bus.clear) begin
            state_d   = S_ACCUM;
            acc_d     = '0;
            cnt_d     = '0;
            ovf_d     = 1'b0;
            out_ovf_d = 1'b0;
        end else begin
            case (state_q)
                S_ACCUM: begin
                    if (accept) begin
                        if (cnt_q == LAST_IDX) begin
                            out_sum_d = sum_kept;
                            out_ovf_d = ovf_q | carry;
                            state_d   = S_DONE;
                            acc_d     = '0;
                            cnt_d     = '0;
                            ovf_d     = 1'b0;
                        end else begin
                            acc_d = sum_kept;
                            cnt_d = cnt_q + 8'd1;
                            ovf_d = ovf_q | carry;
                        end
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        state_d = S_ACCUM;
                    end
                end
                default: state_d = S_ACCUM;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_ACCUM;
            acc_q     <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            out_sum_q <= '0;
            out_ovf_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            ovf_q     <= ovf_d;
            out_sum_q <= out_sum_d;
            out_ovf_q <= out_ovf_d;
        end
    end
endmodule

// File: tb/tb_prod_accumulator.sv
// tb/tb_prod_accumulator.sv - randomized and directed bench for prod_accumulator against a sum-based model
module tb_prod_accumulator;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clear = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_product = 8'd0;
    logic       out_ready = 1'b0;
    bit         mon_en = 1'b0;

    int n_checks = 0;
    int n_pass = 0;

`ifdef ACC_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    always #5 clk = ~clk;

    prod_accumulator_if #(.PROD_W(8), .ACC_W(12)) b0 ();
    prod_accumulator_if #(.PROD_W(8), .ACC_W(9))  b1 ();
    prod_accumulator_if #(.PROD_W(8), .ACC_W(8))  b2 ();

    prod_accumulator #(.PROD_W(8), .ACC_W(12), .COUNT(4)) u0 (.clk(clk), .rst(rst), .bus(b0.slave));
    prod_accumulator #(.PROD_W(8), .ACC_W(9),  .COUNT(4)) u1 (.clk(clk), .rst(rst), .bus(b1.slave));
    prod_accumulator #(.PROD_W(8), .ACC_W(8),  .COUNT(1)) u2 (.clk(clk), .rst(rst), .bus(b2.slave));

    assign b0.clear = clear; assign b0.in_valid = in_valid; assign b0.in_product = in_product; assign b0.out_ready = out_ready;
    assign b1.clear = clear; assign b1.in_valid = in_valid; assign b1.in_product = in_product; assign b1.out_ready = out_ready;
    assign b2.clear = clear; assign b2.in_valid = in_valid; assign b2.in_product = in_product; assign b2.out_ready = out_ready;

    logic        o_ir  [3];
    logic        o_ov  [3];
    logic [11:0] o_sum [3];
    logic        o_ovf [3];
    assign o_ir[0] = b0.in_ready; assign o_ov[0] = b0.out_valid; assign o_sum[0] = b0.out_sum;          assign o_ovf[0] = b0.out_ovf;
    assign o_ir[1] = b1.in_ready; assign o_ov[1] = b1.out_valid; assign o_sum[1] = {3'b0, b1.out_sum}; assign o_ovf[1] = b1.out_ovf;
    assign o_ir[2] = b2.in_ready; assign o_ov[2] = b2.out_valid; assign o_sum[2] = {4'b0, b2.out_sum}; assign o_ovf[2] = b2.out_ovf;

    // Reference model: running integer total of accepted products per result.
    int P_ACCW [3] = '{12, 9, 8};
    int P_CNT  [3] = '{4, 4, 1};
    int m_total [3];
    int m_cnt   [3];
    bit m_pend  [3];
    int m_sum   [3];
    bit m_ovf   [3];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            for (int d = 0; d < 3; d++) begin
                int lim;
                if (!rst) begin
                    check($sformatf("d%0d in_ready", d), 32'(o_ir[d]), 32'(!m_pend[d] && !clear));
                    check($sformatf("d%0d out_valid", d), 32'(o_ov[d]), 32'(m_pend[d] && !clear));
                end
                check($sformatf("d%0d out_sum", d), 32'(o_sum[d]), 32'(m_sum[d]));
                check($sformatf("d%0d out_ovf", d), 32'(o_ovf[d]), 32'(m_ovf[d]));

                lim = 1 << P_ACCW[d];
                if (rst) begin
                    m_total[d] = 0; m_cnt[d] = 0; m_pend[d] = 0; m_sum[d] = 0; m_ovf[d] = 0;
                end else if (clear) begin
                    m_total[d] = 0; m_cnt[d] = 0; m_pend[d] = 0; m_ovf[d] = 0;
                end else if (m_pend[d]) begin
                    if (out_ready) m_pend[d] = 0;
                end else if (in_valid) begin
                    m_total[d] += int'(in_product);
                    m_cnt[d]++;
                    if (m_cnt[d] == P_CNT[d]) begin
                        m_ovf[d] = (m_total[d] >= lim);
                        if (SAT) m_sum[d] = (m_total[d] >= lim) ? lim - 1 : m_total[d];
                        else     m_sum[d] = m_total[d] % lim;
                        m_pend[d]  = 1;
                        m_total[d] = 0;
                        m_cnt[d]   = 0;
                    end
                end
            end
        end
    end

    task automatic drive(input logic v, input logic [7:0] p, input logic ordy, input logic clr);
        in_valid = v; in_product = p; out_ready = ordy; clear = clr;
        @(posedge clk); #1;
    endtask

    initial begin
        in_valid = 1'b1; in_product = 8'd99; out_ready = 1'b1;
        @(posedge clk); #1;
        mon_en = 1'b1;
        @(posedge clk); #1;
        check("rst out_sum", 32'(b0.out_sum), 32'd0);
        check("rst out_ovf", 32'(b0.out_ovf), 32'd0);
        check("rst out_valid", 32'(b0.out_valid), 32'd0);
        rst = 1'b0; in_valid = 1'b0;
        #1 check("post-rst in_ready", 32'(b0.in_ready), 32'd1);

        drive(1, 8'd15, 1, 0); drive(1, 8'd30, 1, 0); drive(1, 8'd45, 1, 0); drive(1, 8'd60, 1, 0);
        check("basic out_valid", 32'(b0.out_valid), 32'd1);
        check("basic out_sum", 32'(b0.out_sum), 32'd150);
        check("basic out_ovf", 32'(b0.out_ovf), 32'd0);
        drive(0, 8'd0, 1, 0);
        check("basic one-cycle valid", 32'(b0.out_valid), 32'd0);

        repeat (4) drive(1, 8'd225, 0, 0);
        for (int i = 0; i < 5; i++) begin
            drive(1, 8'd225, 0, 0);
            check("bp in_ready", 32'(b0.in_ready), 32'd0);
            check("bp out_sum", 32'(b0.out_sum), 32'd900);
            check("ovf9 out_sum", 32'(b1.out_sum), SAT ? 32'd511 : 32'd388);
            check("ovf9 out_ovf", 32'(b1.out_ovf), 32'd1);
        end
        drive(1, 8'd225, 1, 0);
        check("bp release in_ready", 32'(b0.in_ready), 32'd1);
        drive(1, 8'd225, 1, 0);
        drive(0, 8'd0, 1, 1);

        drive(1, 8'd100, 1, 0); drive(1, 8'd100, 1, 0); drive(0, 8'd0, 1, 1);
        drive(1, 8'd1, 1, 0); drive(1, 8'd2, 1, 0); drive(1, 8'd3, 1, 0); drive(1, 8'd4, 1, 0);
        check("clear out_sum", 32'(b0.out_sum), 32'd10);
        check("clear out_ovf", 32'(b0.out_ovf), 32'd0);
        drive(0, 8'd0, 1, 0);

        drive(1, 8'd7, 1, 0); drive(0, 8'd0, 1, 0); drive(1, 8'd8, 1, 0);
        drive(0, 8'd0, 1, 0); drive(1, 8'd9, 1, 0);
        check("gap no early valid", 32'(b0.out_valid), 32'd0);
        drive(1, 8'd10, 1, 0);
        check("gap out_valid", 32'(b0.out_valid), 32'd1);
        check("gap out_sum", 32'(b0.out_sum), 32'd34);
        drive(0, 8'd0, 1, 0);

        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 299) == 0);
            drive(($urandom_range(0, 3) != 0), 8'($urandom), ($urandom_range(0, 2) != 0),
                  ($urandom_range(0, 49) == 0));
        end
        rst = 1'b0;
        drive(0, 8'd0, 1, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
